// File: rtl/vga_pkg.sv
// vga_pkg: framebuffer geometry, colour width and arbiter state encoding shared with the sync generator
package vga_pkg;
    localparam int H_ACTIVE  = 200;
    localparam int V_ACTIVE  = 600;
    localparam int FB_PIXELS = H_ACTIVE * V_ACTIVE;
    localparam int FB_AW     = 17;
    localparam int COLOR_W   = 6;
    typedef enum logic {ST_IDLE, ST_CLEAR} arb_state_e;
endpackage

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares one single-port framebuffer RAM between display fetch, host writes and frame clear
// Ports: clk/reset (sync, active high); CounterX/CounterY from the sync generator;
// host_valid/host_ready/host_addr/host_data/host_clear host write and fill interface; busy while filling;
// mem_addr/mem_we/mem_wdata/mem_rdata RAM port; pixel_color display colour one cycle after the counters.
module vga_fb_arbiter #(
    parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int COLOR_W  = vga_pkg::COLOR_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [9:0]         CounterX,
    input  logic [9:0]         CounterY,
    input  logic               host_valid,
    output logic               host_ready,
    input  logic [16:0]        host_addr,
    input  logic [COLOR_W-1:0] host_data,
    input  logic               host_clear,
    output logic               busy,
    output logic [16:0]        mem_addr,
    output logic               mem_we,
    output logic [COLOR_W-1:0] mem_wdata,
    input  logic [COLOR_W-1:0] mem_rdata,
    output logic [COLOR_W-1:0] pixel_color
);
    import vga_pkg::FB_AW;
    import vga_pkg::arb_state_e;
    import vga_pkg::ST_IDLE;
    import vga_pkg::ST_CLEAR;

    localparam logic [FB_AW-1:0] PIX   = FB_AW'(H_ACTIVE * V_ACTIVE);
    localparam logic [FB_AW-1:0] LAST  = PIX - FB_AW'(1);
    localparam logic [9:0]       H_LIM = 10'(H_ACTIVE);
    localparam logic [9:0]       V_LIM = 10'(V_ACTIVE);

    arb_state_e         state_q, state_d;
    logic [FB_AW-1:0]   fcnt_q, fcnt_d;
    logic [FB_AW-1:0]   idx_q, idx_d;
    logic [COLOR_W-1:0] fill_q, fill_d;
    logic               fetch_d1_q;
    logic               fetch;
    logic [FB_AW-1:0]   fetch_addr;

    // The frame origin forces address 0 in the same cycle, so the fetch
    // address never depends on what the counter held at the end of last frame.
    always_comb begin
        fetch      = (CounterX < H_LIM) && (CounterY < V_LIM);
        fetch_addr = (CounterX == '0 && CounterY == '0) ? '0 : fcnt_q;
        fcnt_d     = fetch ? fetch_addr + FB_AW'(1) : fetch_addr;
        state_d    = state_q;
        idx_d      = idx_q;
        fill_d     = fill_q;
        host_ready = 1'b0;
        busy       = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = fetch ? fetch_addr : '0;
        mem_wdata  = '0;
        if (state_q == ST_IDLE) begin
            host_ready = !fetch && !host_clear;
            if (host_clear) begin
                fill_d  = host_data;
                idx_d   = '0;
                state_d = ST_CLEAR;
            end else if (host_valid && host_ready && host_addr < PIX) begin
                mem_we    = 1'b1;
                mem_addr  = host_addr;
                mem_wdata = host_data;
            end
        end else begin
            busy = 1'b1;
            if (!fetch) begin
                mem_we    = 1'b1;
                mem_addr  = idx_q;
                mem_wdata = fill_q;
                idx_d     = idx_q + FB_AW'(1);
                state_d   = (idx_q == LAST) ? ST_IDLE : ST_CLEAR;
            end
        end
    end

    assign pixel_color = fetch_d1_q ? mem_rdata : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            fcnt_q     <= '0;
            idx_q      <= '0;
            fill_q     <= '0;
            fetch_d1_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            fcnt_q     <= fcnt_d;
            idx_q      <= idx_d;
            fill_q     <= fill_d;
            fetch_d1_q <= fetch;
        end
    end
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb_vga_fb_arbiter: directed bench for vga_fb_arbiter on a reduced 8x6 frame (12x8 total timing)
module tb_vga_fb_arbiter;
    localparam int H = 8, V = 6, HT = 12, VT = 8, NPIX = 48;
    localparam logic [9:0] HL = 10'd8, VL = 10'd6;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [9:0]  cx = 10'd10, cy = 10'd7;
    logic        host_valid = 1'b0, host_clear = 1'b0;
    logic        host_ready, busy, mem_we;
    logic [16:0] host_addr = '0, mem_addr;
    logic [5:0]  host_data = '0, mem_wdata, pixel_color;
    logic [5:0]  mem_rdata = '0;
    logic [5:0]  ram [0:63];
    logic        pre_we = 1'b0;
    logic [5:0]  pre_addr = '0, pre_data = '0;
    logic [5:0]  exp_fill = '0;
    logic        fetch_m;
    int          total = 0, bad = 0;
    int          wr_cnt = 0, wr_fetch = 0, wr_wrong = 0;

    always #5 clk = ~clk;

    assign fetch_m = (cx < HL) && (cy < VL);

    vga_fb_arbiter #(.H_ACTIVE(H), .V_ACTIVE(V), .COLOR_W(6)) dut (
        .clk(clk), .reset(reset), .CounterX(cx), .CounterY(cy),
        .host_valid(host_valid), .host_ready(host_ready), .host_addr(host_addr),
        .host_data(host_data), .host_clear(host_clear), .busy(busy),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .pixel_color(pixel_color)
    );

    always @(posedge clk) begin
        if (pre_we) ram[pre_addr] <= pre_data;
        else if (mem_we && mem_addr < 17'd64) ram[mem_addr[5:0]] <= mem_wdata;
        mem_rdata <= ram[mem_addr[5:0]];
        if (mem_we) begin
            wr_cnt <= wr_cnt + 1;
            if (fetch_m) wr_fetch <= wr_fetch + 1;
            if (mem_wdata !== exp_fill) wr_wrong <= wr_wrong + 1;
        end
    end

    task automatic adv();
        if (cx == 10'(HT - 1)) begin
            cx = '0;
            cy = (cy == 10'(VT - 1)) ? 10'd0 : cy + 10'd1;
        end else cx = cx + 10'd1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        adv();
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL reset_we got=%b exp=0", mem_we); end
        total++; if (pixel_color !== 6'd0) begin bad++; $display("FAIL reset_pixel got=%h exp=0", pixel_color); end
        total++; if (host_ready !== 1'b1) begin bad++; $display("FAIL reset_ready_blank got=%b exp=1", host_ready); end
        total++; if (mem_addr !== 17'd0) begin bad++; $display("FAIL reset_addr got=%0d exp=0", mem_addr); end
        cx = '0; cy = '0;
        #1;
        total++; if (host_ready !== 1'b0) begin bad++; $display("FAIL reset_ready_fetch got=%b exp=0", host_ready); end
        cx = 10'd10; cy = 10'd7;
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
    endtask

    task automatic preload();
        for (int i = 0; i < 64; i++) begin
            pre_we = 1'b1; pre_addr = 6'(i); pre_data = 6'(i);
            @(posedge clk);
            #1;
        end
        pre_we = 1'b0;
        #1;
    endtask

    task automatic test_scan();
        logic pf = 1'b0;
        int   pa = 0;
        cx = '0; cy = '0;
        #1;
        for (int n = 0; n < 2 * HT * VT; n++) begin
            total++;
            if (pixel_color !== (pf ? 6'(pa % 64) : 6'd0)) begin
                bad++; $display("FAIL scan_pixel at n=%0d got=%h exp=%h", n, pixel_color, pf ? 6'(pa % 64) : 6'd0);
            end
            if (pf && pa == 2 * H + 5) begin
                total++; if (pixel_color !== 6'd21) begin bad++; $display("FAIL scan_pixel_5_2 got=%0d exp=21", pixel_color); end
            end
            if (fetch_m) begin
                total++;
                if (mem_addr !== 17'(int'(cy) * H + int'(cx)) || mem_we !== 1'b0 || host_ready !== 1'b0) begin
                    bad++; $display("FAIL scan_fetch_addr x=%0d y=%0d got=%0d we=%b rdy=%b exp=%0d", cx, cy, mem_addr, mem_we, host_ready, int'(cy) * H + int'(cx));
                end
            end
            @(posedge clk);
            #1;
            pf = fetch_m; pa = int'(cy) * H + int'(cx);
            adv();
            #1;
        end
    endtask

    task automatic test_host_wait();
        int  w0 = wr_cnt;
        logic done = 1'b0;
        cx = 10'd2; cy = '0;
        host_valid = 1'b1; host_addr = 17'd10; host_data = 6'h2A; exp_fill = 6'h2A;
        #1;
        for (int k = 0; k < 20 && !done; k++) begin
            if (fetch_m) begin
                total++;
                if (host_ready !== 1'b0 || mem_we !== 1'b0) begin
                    bad++; $display("FAIL wait_blocked x=%0d rdy=%b we=%b exp rdy=0 we=0", cx, host_ready, mem_we);
                end
                tick();
            end else begin
                total++;
                if (cx !== HL || host_ready !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 17'd10 || mem_wdata !== 6'h2A) begin
                    bad++; $display("FAIL wait_accept x=%0d rdy=%b we=%b addr=%0d data=%h exp x=8 rdy=1 we=1 addr=10 data=2a", cx, host_ready, mem_we, mem_addr, mem_wdata);
                end
                done = 1'b1;
                tick();
            end
        end
        host_valid = 1'b0;
        #1;
        total++; if (!done) begin bad++; $display("FAIL wait_timeout got=0 exp=1"); end
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL wait_after_we got=%b exp=0", mem_we); end
        total++; if (wr_cnt - w0 !== 1) begin bad++; $display("FAIL wait_write_count got=%0d exp=1", wr_cnt - w0); end
        total++; if (ram[10] !== 6'h2A) begin bad++; $display("FAIL wait_ram got=%h exp=2a", ram[10]); end
    endtask

    task automatic test_discard();
        cx = 10'd10; cy = '0;
        host_valid = 1'b1; host_addr = 17'd48; host_data = 6'h11;
        #1;
        total++; if (host_ready !== 1'b1) begin bad++; $display("FAIL discard_ready got=%b exp=1", host_ready); end
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL discard_we got=%b exp=0", mem_we); end
        host_addr = 17'd47;
        #1;
        total++;
        if (mem_we !== 1'b1 || mem_addr !== 17'd47 || mem_wdata !== 6'h11) begin
            bad++; $display("FAIL last_addr_write we=%b addr=%0d data=%h exp we=1 addr=47 data=11", mem_we, mem_addr, mem_wdata);
        end
        host_valid = 1'b0;
        #1;
        total++;
        if (mem_we !== 1'b0 || mem_addr !== 17'd0 || mem_wdata !== 6'd0) begin
            bad++; $display("FAIL idle_outputs we=%b addr=%0d data=%h exp all 0", mem_we, mem_addr, mem_wdata);
        end
    endtask

    task automatic test_clear();
        int   w0, f0, x0;
        logic last = 1'b0, done = 1'b0;
        cx = '0; cy = 10'd6;
        exp_fill = 6'h15;
        host_clear = 1'b1; host_valid = 1'b1; host_addr = 17'd5; host_data = 6'h15;
        #1;
        total++; if (host_ready !== 1'b0 || mem_we !== 1'b0) begin bad++; $display("FAIL clear_vs_valid rdy=%b we=%b exp 0 0", host_ready, mem_we); end
        w0 = wr_cnt; f0 = wr_fetch; x0 = wr_wrong;
        tick();
        host_clear = 1'b0; host_valid = 1'b0; host_data = 6'h3F;
        #1;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL clear_busy got=%b exp=1", busy); end
        for (int k = 0; k < 400 && !done; k++) begin
            host_clear = (k == 10);
            #1;
            if (last) begin
                total++; if (busy !== 1'b0) begin bad++; $display("FAIL clear_busy_fall got=%b exp=0", busy); end
                done = 1'b1;
            end else if (mem_we && mem_addr == 17'(NPIX - 1)) begin
                total++; if (busy !== 1'b1) begin bad++; $display("FAIL clear_last_busy got=%b exp=1", busy); end
                last = 1'b1;
            end
            tick();
        end
        host_clear = 1'b0;
        total++; if (!done) begin bad++; $display("FAIL clear_timeout got=0 exp=1"); end
        total++; if (wr_cnt - w0 !== NPIX) begin bad++; $display("FAIL clear_count got=%0d exp=%0d", wr_cnt - w0, NPIX); end
        total++; if (wr_fetch - f0 !== 0) begin bad++; $display("FAIL clear_on_fetch got=%0d exp=0", wr_fetch - f0); end
        total++; if (wr_wrong - x0 !== 0) begin bad++; $display("FAIL clear_colour got=%0d exp=0", wr_wrong - x0); end
        for (int k = 0; k < 200 && !(cx == 10'd0 && cy == 10'd0); k++) tick();
        for (int n = 0; n < HT * VT; n++) begin
            logic pf = fetch_m;
            tick();
            if (pf) begin
                total++; if (pixel_color !== 6'h15) begin bad++; $display("FAIL clear_frame n=%0d got=%h exp=15", n, pixel_color); end
            end
        end
    endtask

    task automatic test_reset_mid_clear();
        int w0;
        exp_fill = 6'h2C;
        host_clear = 1'b1; host_data = 6'h2C;
        tick();
        host_clear = 1'b0;
        w0 = wr_cnt;
        for (int k = 0; k < 200 && wr_cnt - w0 < 20; k++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", busy); end
        w0 = wr_cnt;
        for (int k = 0; k < 100; k++) tick();
        total++; if (wr_cnt - w0 !== 0) begin bad++; $display("FAIL abort_writes got=%0d exp=0", wr_cnt - w0); end
        for (int k = 0; k < 100 && fetch_m; k++) tick();
        total++; if (host_ready !== 1'b1 || fetch_m) begin bad++; $display("FAIL abort_ready got=%b exp=1", host_ready); end
    endtask

    initial begin
        test_reset();
        preload();
        test_scan();
        test_host_wait();
        test_discard();
        test_clear();
        test_reset_mid_clear();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/vga_fb_arbiter.md
VGA_FB_ARBITER -- requirements
Module: vga_fb_arbiter

Interface
REQ-001 Parameter H_ACTIVE, default 200, visible pixels per line.
REQ-002 Parameter V_ACTIVE, default 600, visible lines per frame.
REQ-003 Parameter COLOR_W, default 6, pixel colour width (64 colours).
REQ-004 Port clk  input  1  the single clock; all logic SHALL be clocked on its rising edge.
REQ-005 Port reset  input  1  synchronous, active-high reset, sampled on clk rising edge.
REQ-006 Port CounterX  input  10  horizontal counter from the sync generator, same cycle.
REQ-007 Port CounterY  input  10  vertical counter from the sync generator, same cycle.
REQ-008 Port host_valid  input  1  host write request.
REQ-009 Port host_ready  output  1  host write accepted this cycle when host_valid=1.
REQ-010 Port host_addr  input  17  framebuffer pixel index, row-major (y*H_ACTIVE+x).
REQ-011 Port host_data  input  COLOR_W  write colour, also the fill colour for clear.
REQ-012 Port host_clear  input  1  single-cycle pulse: fill the whole frame with host_data.
REQ-013 Port busy  output  1  clear in progress.
REQ-014 Port mem_addr  output  17  single-port RAM address.
REQ-015 Port mem_we  output  1  RAM write enable.
REQ-016 Port mem_wdata  output  COLOR_W  RAM write data.
REQ-017 Port mem_rdata  input  COLOR_W  RAM read data, valid one cycle after address.
REQ-018 Port pixel_color  output  COLOR_W  display colour, aligned with generator's registered inDisplayArea/sync outputs.

Function
REQ-019 fetch = (CounterX < H_ACTIVE) && (CounterY < V_ACTIVE), combinational; fetch SHALL own the RAM with absolute priority.
REQ-020 Fetch address counter SHALL load 0 when CounterX==0 and CounterY==0, else increment by 1 on every fetch cycle; mem_addr = counter, mem_we=0 on fetch cycles.
REQ-021 fetch_d1 register SHALL capture fetch; pixel_color = fetch_d1 ? mem_rdata : 0 (one-cycle latency from counters).
REQ-022 FSM states IDLE and CLEAR; reset state IDLE.
REQ-023 IDLE: host_ready = !fetch && !host_clear; transfer when host_valid && host_ready.
REQ-024 Transfer with host_addr < H_ACTIVE*V_ACTIVE SHALL drive mem_we=1, mem_addr=host_addr, mem_wdata=host_data in the same cycle.
REQ-025 Transfer with host_addr >= H_ACTIVE*V_ACTIVE SHALL be accepted and discarded (mem_we=0).
REQ-026 IDLE and host_clear=1: latch host_data as fill colour, clear index := 0, go to CLEAR; clear wins over a simultaneous host_valid (no transfer).
REQ-027 CLEAR: host_ready=0, busy=1; each non-fetch cycle writes fill colour at clear index and increments it; fetch cycles stall the index.
REQ-028 CLEAR: write of index H_ACTIVE*V_ACTIVE-1 SHALL return to IDLE next cycle; busy falls with it.
REQ-029 host_clear during CLEAR SHALL be ignored.
REQ-030 Idle cycles (no fetch, no transfer, no clear write): mem_we=0, mem_addr=0, mem_wdata=0.
REQ-031 Arithmetic: counters 17 bits unsigned; H_ACTIVE*V_ACTIVE (120000) SHALL fit without wrap.

Reset
REQ-032 During reset: state IDLE, fetch counter 0, clear index 0, fill colour 0, fetch_d1 0.
REQ-033 Outputs during/after reset: host_ready per REQ-023, busy 0, mem_we 0, pixel_color 0.
REQ-034 Reset mid-clear SHALL abort the fill; no further clear writes occur.

Structure
REQ-035 Package vga_pkg SHALL hold H_ACTIVE, V_ACTIVE, FB_PIXELS, FB_AW=17, COLOR_W and the FSM state encoding, shared with the sync generator.
REQ-036 Single module, no sub-module; sync generator instantiated beside it at top level, not inside.

Verification
REQ-037 Frame scan with RAM preloaded addr=value mod 64 -> pixel_color at (x=5,y=2) equals (2*200+5) mod 64 = 21, one cycle after counters show (5,2).
REQ-038 host_valid held, addr=1000, data=0x2A, issued at CounterX=10,Y=0 -> host_ready=0 until CounterX=200, then one write of 0x2A at 1000.
REQ-039 host_addr=120000 during blanking -> host_ready=1, mem_we stays 0.
REQ-040 host_clear with data=0x15 at CounterY=600 -> busy=1, 120000 writes of 0x15 with none on fetch cycles, busy=0 after last; following frame shows 0x15 everywhere.
REQ-041 host_clear and host_valid same cycle -> no host write, CLEAR entered.
REQ-042 reset asserted after 500 clear writes -> busy=0 next cycle, no further mem_we, host_ready resumes.
